// File: rtl/keypad_encoder.sv
// Purpose: scans a 4x4 active-low keypad, debounces one key at a time and encodes digits/'#'.
// Latency: pulse at t0 + (DEBOUNCE-1)*SCAN_DIV + 1 after the first detecting sample t0.
// Backpressure: none; key_valid/enter are single-cycle pulses that must be consumed when seen.
//
// Ports:
//   clk, reset   - single rising-edge clock, synchronous active-high reset
//   col_in[3:0]  - column sense lines, active-low (0 = key closed on the driven row)
//   row_out[3:0] - row drive, active-low, exactly one bit low
//   key_in[3:0]  - last accepted digit 0-9 (meaningful while key_valid = 1)
//   key_valid    - one-cycle pulse, a new digit is on key_in
//   enter        - one-cycle pulse, '#' accepted
module keypad_encoder #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_in,
    output logic       key_valid,
    output logic       enter
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE   = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_EMIT,
        ST_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [DIV_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cap_q, cap_d;
    logic [3:0]       key_q, key_d;

    logic       sample;
    logic       one_low;
    logic [1:0] col_idx;
    logic       is_digit;
    logic       is_hash;
    logic [3:0] digit_val;
    logic [3:0] row_ext;
    logic [3:0] col_ext;

    // Columns are only looked at on the last cycle of each row dwell so the
    // row drive has settled through the keypad wiring.
    assign sample  = (dwell_q == DWELL_LAST);
    assign row_out = ~(4'b0001 << row_q);

    // Exactly one column low; zero or several (ghosting) are ignored.
    always_comb begin
        one_low = 1'b0;
        case (col_in)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
            default:                            one_low = 1'b0;
        endcase
    end

    // Column index of the captured pattern (always one-hot-low once captured).
    always_comb begin
        col_idx = 2'd3;
        case (cap_q)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            default: col_idx = 2'd3;
        endcase
    end

    // Rows 0-2, columns 0-2 hold digits 1-9 in reading order; row 3 is *,0,#,D.
    assign row_ext = {2'b00, row_q};
    assign col_ext = {2'b00, col_idx};

    always_comb begin
        is_digit  = 1'b0;
        is_hash   = 1'b0;
        digit_val = 4'd0;
        if (row_q != 2'd3) begin
            if (col_idx != 2'd3) begin
                is_digit  = 1'b1;
                digit_val = row_ext * 4'd3 + col_ext + 4'd1;
            end
        end else begin
            if (col_idx == 2'd1) begin
                is_digit  = 1'b1;
                digit_val = 4'd0;
            end else if (col_idx == 2'd2) begin
                is_hash = 1'b1;
            end
        end
    end

    // Next-state and outputs.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        dwell_d   = sample ? '0 : dwell_q + 1'b1;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        key_d     = key_q;
        key_in    = key_q;
        key_valid = 1'b0;
        enter     = 1'b0;

        case (state_q)
            ST_SCAN: begin
                if (sample) begin
                    if (one_low) begin
                        // Row stays put: row_q doubles as the captured row.
                        cap_d   = col_in;
                        cnt_d   = CNT_ONE;
                        state_d = (DEBOUNCE == 1) ? ST_EMIT : ST_DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
            end

            ST_DEBOUNCE: begin
                if (sample) begin
                    if (col_in == cap_q) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q + 1'b1 == CNT_DONE) begin
                            state_d = ST_EMIT;
                        end
                    end else begin
                        cnt_d   = '0;
                        row_d   = row_q + 2'd1;
                        state_d = ST_SCAN;
                    end
                end
            end

            ST_EMIT: begin
                // Restart the dwell so release sampling is SCAN_DIV apart from here.
                dwell_d = '0;
                cnt_d   = '0;
                state_d = ST_RELEASE;
                if (is_digit) begin
                    key_valid = 1'b1;
                    key_in    = digit_val;
                    key_d     = digit_val;
                end else if (is_hash) begin
                    enter = 1'b1;
                end
            end

            ST_RELEASE: begin
                if (sample) begin
                    if (col_in == 4'hF) begin
                        if (cnt_q + 1'b1 == CNT_DONE) begin
                            cnt_d   = '0;
                            row_d   = row_q + 2'd1;
                            state_d = ST_SCAN;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        // Any bounce back to closed restarts the release count.
                        cnt_d = '0;
                    end
                end
            end

            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SCAN;
            row_q   <= 2'd0;
            dwell_q <= '0;
            cnt_q   <= '0;
            cap_q   <= 4'hF;
            key_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            key_q   <= key_d;
        end
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Purpose: directed bench for keypad_encoder (SCAN_DIV=4, DEBOUNCE=3) with a keypad model.
// Latency: cycle numbers below count from the first cycle after reset is released.
// Backpressure: n/a.
module tb_keypad_encoder;

    logic       clk;
    logic       reset;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_in;
    logic       key_valid;
    logic       enter;

    // kp[r] bit c = key (r,c) physically closed.
    logic [3:0][3:0] kp;

    int checks;
    int errors;
    int cyc;
    int vcnt, ecnt, both_total, last_key, pulse_at;

    keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_in    (key_in),
        .key_valid (key_valid),
        .enter     (enter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive keypad: a closed key pulls its column low while its row is driven.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_out[r]) col_in = col_in & ~kp[r];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Sample outputs at the falling edge of the current cycle, then advance.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (key_valid) begin
                vcnt++;
                last_key = int'(key_in);
                pulse_at = cyc;
            end
            if (enter) ecnt++;
            if (key_valid && enter) both_total++;
            cyc++;
        end
    endtask

    // Return at the falling edge of cycle k.
    task automatic goto_cyc(input int k);
        while (cyc <= k) tick(1);
    endtask

    task automatic clear_counts();
        vcnt     = 0;
        ecnt     = 0;
        last_key = -1;
        pulse_at = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        clear_counts();
    endtask

    typedef struct {
        int       row;
        logic [3:0] cols;
        int       exp_valid;
        int       exp_key;
        int       exp_enter;
        bit       hold_row;
    } vec_t;

    typedef struct {
        int         at;
        logic [3:0] row;
    } rot_t;

    vec_t vecs[12];
    rot_t rots[7];

    initial begin
        checks     = 0;
        errors     = 0;
        both_total = 0;
        kp         = '0;
        reset      = 1'b1;
        cyc        = 0;
        clear_counts();

        // row, column mask, #key_valid, key, #enter, row held at end of press
        vecs[0]  = '{1, 4'b0001, 1, 4, 0, 1'b1};   // 4
        vecs[1]  = '{0, 4'b0010, 1, 2, 0, 1'b1};   // 2
        vecs[2]  = '{2, 4'b0001, 1, 7, 0, 1'b1};   // 7
        vecs[3]  = '{2, 4'b0100, 1, 9, 0, 1'b1};   // 9
        vecs[4]  = '{3, 4'b0100, 0, 0, 1, 1'b1};   // #
        vecs[5]  = '{3, 4'b0001, 0, 0, 0, 1'b1};   // *
        vecs[6]  = '{0, 4'b1000, 0, 0, 0, 1'b1};   // A
        vecs[7]  = '{0, 4'b0011, 0, 0, 0, 1'b0};   // 1+2 ghost
        vecs[8]  = '{0, 4'b0100, 1, 3, 0, 1'b1};   // 3
        vecs[9]  = '{3, 4'b0010, 1, 0, 0, 1'b1};   // 0
        vecs[10] = '{1, 4'b0100, 1, 6, 0, 1'b1};   // 6
        vecs[11] = '{3, 4'b1000, 0, 0, 0, 1'b1};   // D

        rots[0] = '{0,  4'b1110};
        rots[1] = '{3,  4'b1110};
        rots[2] = '{4,  4'b1101};
        rots[3] = '{8,  4'b1011};
        rots[4] = '{12, 4'b0111};
        rots[5] = '{15, 4'b0111};
        rots[6] = '{16, 4'b1110};

        // Reset state and idle row rotation.
        do_reset();
        goto_cyc(0);
        check("rst_row_out", int'(row_out), 4'b1110);
        check("rst_key_in", int'(key_in), 0);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_enter", int'(enter), 0);
        foreach (rots[i]) begin
            goto_cyc(rots[i].at);
            check($sformatf("rot_c%0d", rots[i].at), int'(row_out), int'(rots[i].row));
        end

        // '4' held through reset and for 200 cycles: t0 = 7, pulse at 16.
        kp[1] = 4'b0001;
        do_reset();
        goto_cyc(15);
        check("hold4_early", vcnt, 0);
        goto_cyc(16);
        check("hold4_pulse_now", int'(key_valid), 1);
        check("hold4_key_in", int'(key_in), 4);
        goto_cyc(199);
        check("hold4_count", vcnt, 1);
        check("hold4_at", pulse_at, 16);
        check("hold4_enter", ecnt, 0);
        check("hold4_row_held", int'(row_out), 4'b1101);
        kp = '0;
        tick(30);
        check("hold4_after_rel", vcnt, 1);

        // '5' seen by one sample only (cycle 7), gone by the cycle-11 sample.
        do_reset();
        goto_cyc(5);
        kp[1] = 4'b0010;
        goto_cyc(9);
        kp[1] = 4'b0000;
        goto_cyc(10);
        check("bounce_row_c10", int'(row_out), 4'b1101);
        goto_cyc(12);
        check("bounce_row_c12", int'(row_out), 4'b1011);
        goto_cyc(16);
        check("bounce_row_c16", int'(row_out), 4'b0111);
        goto_cyc(20);
        check("bounce_row_c20", int'(row_out), 4'b1110);
        goto_cyc(24);
        check("bounce_row_c24", int'(row_out), 4'b1101);
        goto_cyc(100);
        check("bounce_valid", vcnt, 0);

        // Reset in the middle of debouncing '8' (detected at cycle 11, would emit at 20).
        do_reset();
        kp[2] = 4'b0010;
        goto_cyc(12);
        check("rst8_row_held", int'(row_out), 4'b1011);
        goto_cyc(13);
        reset = 1'b1;
        kp    = '0;
        goto_cyc(14);
        check("rst8_row_after", int'(row_out), 4'b1110);
        reset = 1'b0;
        tick(100);
        check("rst8_valid", vcnt, 0);
        check("rst8_enter", ecnt, 0);

        // Press/release sequence, 60 cycles held and 60 released per key.
        do_reset();
        foreach (vecs[i]) begin
            clear_counts();
            kp[vecs[i].row] = vecs[i].cols;
            tick(60);
            if (vecs[i].hold_row)
                check($sformatf("v%0d_row_held", i), int'(row_out),
                      int'(~(4'b0001 << vecs[i].row) & 4'hF));
            kp = '0;
            tick(60);
            check($sformatf("v%0d_valid_cnt", i), vcnt, vecs[i].exp_valid);
            check($sformatf("v%0d_enter_cnt", i), ecnt, vecs[i].exp_enter);
            if (vecs[i].exp_valid != 0)
                check($sformatf("v%0d_key", i), last_key, vecs[i].exp_key);
        end

        check("valid_enter_overlap", both_total, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
